mole_led_driver: RTL and testbench

- Parametrised successor of the combinational mole-to-LED decoder.
- Drives NUM_LEDS registered LED outputs from NUM_SLOTS mole positions.
- Adds a per-LED hit-flash effect and a global game-over blink mode, both timed by an external tick enable.
- Sits between the mole scheduler/hit detector and the board LED pins.

---
 rtl/mole_led_driver.sv | 121 ++++++++++++
 tb/tb_mole_led_driver.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mole_led_driver.sv
// Registered mole-position LED driver with per-LED hit flash and a game-over blink mode.
// All timers advance only on cycles where tick is high.
module mole_led_driver #(
  parameter int unsigned NUM_LEDS    = 8,
  parameter int unsigned NUM_SLOTS   = 2,
  parameter int unsigned POS_W       = 4,
  parameter int unsigned BLINK_TICKS = 4,
  parameter int unsigned FLASH_TICKS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic [NUM_SLOTS*POS_W-1:0] mole_pos,
  input  logic                       hit_valid,
  input  logic [POS_W-1:0]           hit_pos,
  input  logic                       game_over,
  input  logic                       clear,
  output logic [NUM_LEDS-1:0]        leds,
  output logic                       flashing
);

  localparam int unsigned CNT_W = $clog2(FLASH_TICKS + 1);
  localparam int unsigned DIV_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  typedef enum logic {
    ST_NORMAL,
    ST_GAME_OVER
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt     [NUM_LEDS];
  logic [CNT_W-1:0]    w_cnt_nxt [NUM_LEDS];
  logic [DIV_W-1:0]    r_div;
  logic [DIV_W-1:0]    w_div_nxt;
  logic                r_phase;
  logic                w_phase_nxt;
  logic [NUM_LEDS-1:0] w_mole_map;
  logic [NUM_LEDS-1:0] w_hit_sel;
  logic [NUM_LEDS-1:0] w_leds_nxt;
  logic                w_flash_nxt;
  logic [NUM_LEDS-1:0] r_leds;
  logic                r_flashing;

  // Position decode: 0 and out-of-range positions match no LED.
  always_comb begin
    w_mole_map = '0;
    w_hit_sel  = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
        if (mole_pos[k*POS_W +: POS_W] == POS_W'(i + 1)) w_mole_map[i] = 1'b1;
      end
      w_hit_sel[i] = hit_valid && (r_state == ST_NORMAL) && (hit_pos == POS_W'(i + 1));
    end
  end

  // game_over has priority over clear.
  always_comb begin
    w_state_nxt = r_state;
    if (game_over)  w_state_nxt = ST_GAME_OVER;
    else if (clear) w_state_nxt = ST_NORMAL;
  end

  always_comb begin
    w_div_nxt   = r_div;
    w_phase_nxt = r_phase;
    if (tick) begin
      if (r_div == DIV_W'(BLINK_TICKS - 1)) begin
        w_div_nxt   = '0;
        w_phase_nxt = ~r_phase;
      end else begin
        w_div_nxt = r_div + 1'b1;
      end
    end
  end

  // Counters are already zero while in GAME_OVER, so zeroing whenever the next
  // state is GAME_OVER is equivalent to zeroing only on entry.
  always_comb begin
    w_flash_nxt = 1'b0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_state_nxt == ST_GAME_OVER)    w_cnt_nxt[i] = '0;
      else if (w_hit_sel[i])              w_cnt_nxt[i] = CNT_W'(FLASH_TICKS);
      else if (tick && (r_cnt[i] != '0))  w_cnt_nxt[i] = r_cnt[i] - 1'b1;
      if (w_cnt_nxt[i] != '0) w_flash_nxt = 1'b1;
    end
  end

  // LED image uses the current registered mode/phase/counters; flashing uses post-update counters.
  always_comb begin
    w_leds_nxt = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      if (r_state == ST_GAME_OVER) w_leds_nxt[i] = r_phase;
      else if (r_cnt[i] != '0)     w_leds_nxt[i] = r_phase;
      else                         w_leds_nxt[i] = w_mole_map[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_NORMAL;
      r_div      <= '0;
      r_phase    <= 1'b1;
      r_leds     <= '0;
      r_flashing <= 1'b0;
      for (int unsigned i = 0; i < NUM_LEDS; i++) r_cnt[i] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_div      <= w_div_nxt;
      r_phase    <= w_phase_nxt;
      r_leds     <= w_leds_nxt;
      r_flashing <= w_flash_nxt;
      for (int unsigned i = 0; i < NUM_LEDS; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  assign leds     = r_leds;
  assign flashing = r_flashing;

endmodule

// File: tb/tb_mole_led_driver.sv
// Directed bench for mole_led_driver: BLINK_TICKS=2, FLASH_TICKS=6, tick held high.
// Edge n counts rising edges after reset release; blink phase after edge n is 1,1,0,0,1,1,0,0,...
module tb_mole_led_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b1;
  logic [7:0] mole_pos = '0;
  logic       hit_valid = 1'b0;
  logic [3:0] hit_pos = '0;
  logic       game_over = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] leds;
  logic       flashing;

  int n_checks = 0;
  int n_pass   = 0;

  mole_led_driver #(
    .NUM_LEDS   (8),
    .NUM_SLOTS  (2),
    .POS_W      (4),
    .BLINK_TICKS(2),
    .FLASH_TICKS(6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .mole_pos (mole_pos),
    .hit_valid(hit_valid),
    .hit_pos  (hit_pos),
    .game_over(game_over),
    .clear    (clear),
    .leds     (leds),
    .flashing (flashing)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic [7:0] exp_l, input logic exp_f);
    step();
    check({tag, " leds"}, 32'(leds), 32'(exp_l));
    check({tag, " flashing"}, 32'(flashing), 32'(exp_f));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mole_pos  = '0;
    hit_valid = 1'b0;
    hit_pos   = '0;
    game_over = 1'b0;
    clear     = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  logic [7:0] flash_l [7] = '{8'h20, 8'h20, 8'h24, 8'h24, 8'h20, 8'h20, 8'h24};
  logic       flash_f [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  int         flash_cycles;

  initial begin
    // reset state
    do_reset();
    check("reset leds", 32'(leds), 32'h00);
    check("reset flashing", 32'(flashing), 32'h0);

    // position decode
    mole_pos = 8'h03; step_chk("dec 3,0", 8'h04, 1'b0);
    mole_pos = 8'h55; step_chk("dec 5,5", 8'h10, 1'b0);
    mole_pos = 8'h81; step_chk("dec 1,8", 8'h81, 1'b0);
    mole_pos = 8'h09; step_chk("dec 9,0", 8'h00, 1'b0);
    mole_pos = 8'hF0; step_chk("dec 0,15", 8'h00, 1'b0);

    // out-of-range hits load nothing
    mole_pos = 8'h00;
    hit_valid = 1'b1;
    hit_pos = 4'd0;  step_chk("hit 0", 8'h00, 1'b0);
    hit_pos = 4'd12; step_chk("hit 12", 8'h00, 1'b0);
    hit_pos = 4'd9;  step_chk("hit 9", 8'h00, 1'b0);
    hit_valid = 1'b0;
    step_chk("hit oor settle", 8'h00, 1'b0);

    // hit flash on LED 3 with a steady mole on LED 6
    do_reset();
    mole_pos = 8'h63;
    step_chk("flash e1", 8'h24, 1'b0);
    hit_valid = 1'b1; hit_pos = 4'd3;
    step_chk("flash e2", 8'h24, 1'b1);
    hit_valid = 1'b0;
    for (int i = 0; i < 7; i++) step_chk($sformatf("flash e%0d", i + 3), flash_l[i], flash_f[i]);

    // re-hit after 4 ticks reloads the counter: 10 flash cycles total
    do_reset();
    mole_pos = 8'h03;
    hit_pos = 4'd3;
    flash_cycles = 0;
    for (int e = 1; e <= 14; e++) begin
      hit_valid = (e == 2) || (e == 6);
      step();
      hit_valid = 1'b0;
      if (flashing === 1'b1) flash_cycles++;
      if (e == 11) check("rehit e11 flashing", 32'(flashing), 32'h1);
      if (e == 12) check("rehit e12 flashing", 32'(flashing), 32'h0);
    end
    check("rehit flash cycles", 32'(flash_cycles), 32'd10);

    // game-over mode
    do_reset();
    mole_pos = 8'h03;
    hit_valid = 1'b1; hit_pos = 4'd3;
    step_chk("go e1", 8'h04, 1'b1);
    hit_valid = 1'b0; game_over = 1'b1;
    step_chk("go e2 enter", 8'h04, 1'b0);
    game_over = 1'b0; hit_valid = 1'b1;
    step_chk("go e3 hit ignored", 8'h00, 1'b0);
    hit_valid = 1'b0;
    step_chk("go e4", 8'h00, 1'b0);
    step_chk("go e5", 8'hFF, 1'b0);
    mole_pos = 8'h81;
    step_chk("go e6", 8'hFF, 1'b0);
    game_over = 1'b1; clear = 1'b1;
    step_chk("go e7 both", 8'h00, 1'b0);
    game_over = 1'b0; clear = 1'b0;
    step_chk("go e8 stays", 8'h00, 1'b0);
    clear = 1'b1;
    step_chk("go e9 clear", 8'hFF, 1'b0);
    clear = 1'b0;
    step_chk("go e10 normal", 8'h81, 1'b0);

    // asynchronous reset mid-flash
    do_reset();
    mole_pos = 8'h03;
    hit_valid = 1'b1; hit_pos = 4'd3;
    step();
    hit_valid = 1'b0;
    step_chk("arst pre", 8'h04, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("arst leds", 32'(leds), 32'h00);
    check("arst flashing", 32'(flashing), 32'h0);
    #2;
    rst = 1'b0;
    mole_pos = 8'h03; game_over = 1'b1;
    step_chk("arst e1 normal", 8'h04, 1'b0);
    game_over = 1'b0;
    step_chk("arst e2 phase", 8'hFF, 1'b0);
    step_chk("arst e3 phase", 8'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
